regfile_port_initiator: RTL and testbench

Initiator-side controller for one port of the dual-port register-file RAM. It owns that port's en/we/addr/data signals. After reset or on command it sweeps every RAM word to a clear value. It then serves single-word read/write requests from a pipeline client over a valid/ready handshake and returns read data with a valid pulse.

---
 rtl/regfile_port_initiator_if.sv | 25 ++
 rtl/regfile_port_initiator.sv | 131 +++++++++++++
 tb/tb_regfile_port_initiator.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_port_initiator_if.sv
// Client request/response bundle for one register-file port controller.
// Master drives requests and consumes responses; slave is the controller.
// Request is a valid/ready handshake; the response is a one-cycle valid pulse.
interface regfile_port_initiator_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  reqValid;
   logic                  reqReady;
   logic                  reqWe;
   logic [ADDR_WIDTH-1:0] reqAddr;
   logic [DATA_WIDTH-1:0] reqData;
   logic                  rspValid;
   logic [DATA_WIDTH-1:0] rspData;

   modport master (
      output reqValid, reqWe, reqAddr, reqData,
      input  reqReady, rspValid, rspData
   );

   modport slave (
      input  reqValid, reqWe, reqAddr, reqData,
      output reqReady, rspValid, rspData
   );
endinterface

// File: rtl/regfile_port_initiator.sv
// Initiator for one register-file RAM port: clear sweep after reset/on command, then single-word client reads/writes.
// Latency: RAM controls registered at posedge (RAM acts at next negedge); read data returned 1 cycle after accept.
// Backpressure: reqReady is low during a sweep and in any cycle iClear is high; responses cannot be stalled.
module regfile_port_initiator #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 5,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
   parameter bit                    ZERO_REG    = 1'b1
) (
   input  logic                  iClk,
   input  logic                  iRst_n,
   input  logic                  iClear,
   regfile_port_initiator_if.slave req,
   output logic                  oInitDone,
   output logic                  oRamEn,
   output logic                  oRamWe,
   output logic [ADDR_WIDTH-1:0] oRamAddr,
   output logic [DATA_WIDTH-1:0] oRamData,
   input  logic [DATA_WIDTH-1:0] iRamData
);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                state;
   state_t                stateNext;
   // One extra bit so the sweep end is seen as the MSB setting, never as a wrap to 0.
   logic [ADDR_WIDTH:0]   cnt;
   logic [ADDR_WIDTH:0]   cntNext;
   logic                  ramEnNext;
   logic                  ramWeNext;
   logic [ADDR_WIDTH-1:0] ramAddrNext;
   logic [DATA_WIDTH-1:0] ramDataNext;
   logic                  initDoneNext;
   logic                  rdPend;
   logic                  rdPendNext;
   logic                  rdZero;
   logic                  rdZeroNext;
   logic                  reqIsZero;

   // Address 0 is a hardwired zero register when ZERO_REG is set.
   assign reqIsZero    = ZERO_REG && (req.reqAddr == '0);
   // Clear wins over a request presented in the same cycle.
   assign req.reqReady = (state == RUN) && !iClear;

   // State and sweep counter register.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   // Next-state and next RAM command: sweep writes in CLEAR, client requests in RUN.
   always_comb begin
      stateNext    = state;
      cntNext      = cnt;
      ramEnNext    = 1'b0;
      ramWeNext    = 1'b0;
      ramAddrNext  = oRamAddr;
      ramDataNext  = oRamData;
      initDoneNext = oInitDone;
      rdPendNext   = 1'b0;
      rdZeroNext   = rdZero;
      case (state)
         CLEAR: begin
            if (cnt[ADDR_WIDTH]) begin
               stateNext    = RUN;
               initDoneNext = 1'b1;
            end else begin
               ramEnNext   = 1'b1;
               ramWeNext   = 1'b1;
               ramAddrNext = cnt[ADDR_WIDTH-1:0];
               ramDataNext = CLEAR_VALUE;
               cntNext     = cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end
         end
         RUN: begin
            if (iClear) begin
               stateNext = CLEAR;
               cntNext   = '0;
            end else if (req.reqValid) begin
               ramEnNext   = 1'b1;
               ramWeNext   = req.reqWe && !reqIsZero;
               ramAddrNext = req.reqAddr;
               ramDataNext = req.reqData;
               rdPendNext  = !req.reqWe;
               rdZeroNext  = reqIsZero;
            end
         end
         default: stateNext = CLEAR;
      endcase
   end

   // Registered RAM port controls, init flag and outstanding-read tracking.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         oRamEn    <= 1'b0;
         oRamWe    <= 1'b0;
         oRamAddr  <= '0;
         oRamData  <= '0;
         oInitDone <= 1'b0;
         rdPend    <= 1'b0;
         rdZero    <= 1'b0;
      end else begin
         oRamEn    <= ramEnNext;
         oRamWe    <= ramWeNext;
         oRamAddr  <= ramAddrNext;
         oRamData  <= ramDataNext;
         oInitDone <= initDoneNext;
         rdPend    <= rdPendNext;
         rdZero    <= rdZeroNext;
      end
   end

   // Capture RAM read data one cycle after a read accept; zero register reads as 0.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         req.rspValid <= 1'b0;
         req.rspData  <= '0;
      end else begin
         req.rspValid <= rdPend;
         if (rdPend) begin
            req.rspData <= rdZero ? '0 : iRamData;
         end
      end
   end

endmodule

// File: tb/tb_regfile_port_initiator.sv
// Bench for regfile_port_initiator: behavioural negedge RAM, reference memory and response scoreboard.
// Read expectations are queued at accept time and matched against each response pulse.
// Covers reset, init sweep, read/write, zero register, back-to-back reads, clear-vs-request and mid-sweep reset.
module tb_regfile_port_initiator;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int DEPTH = 1 << AW;

   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   logic          iClk;
   logic          iRst_n;
   logic          iClear;
   logic          oInitDone;
   logic          oRamEn;
   logic          oRamWe;
   logic [AW-1:0] oRamAddr;
   logic [DW-1:0] oRamData;
   logic [DW-1:0] iRamData;

   logic [DW-1:0] ramArr [DEPTH];
   logic [DW-1:0] refMem [DEPTH];
   exp_t          sb [$];
   int            cyc = 0;
   int            total = 0;
   int            bad = 0;

   regfile_port_initiator_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) reqIf ();

   regfile_port_initiator #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .CLEAR_VALUE('0),
      .ZERO_REG   (1'b1)
   ) dut (
      .iClk     (iClk),
      .iRst_n   (iRst_n),
      .iClear   (iClear),
      .req      (reqIf),
      .oInitDone(oInitDone),
      .oRamEn   (oRamEn),
      .oRamWe   (oRamWe),
      .oRamAddr (oRamAddr),
      .oRamData (oRamData),
      .iRamData (iRamData)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   always @(posedge iClk) cyc++;

   // Read-first RAM port acting on the falling edge.
   initial begin
      for (int i = 0; i < DEPTH; i++) ramArr[i] = 32'hA5A50000 | i;
      iRamData = '0;
   end
   always @(negedge iClk) begin
      if (oRamEn) begin
         if (oRamWe) ramArr[oRamAddr] <= oRamData;
         iRamData <= ramArr[oRamAddr];
      end
   end

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Response monitor: every pulse must match the oldest queued read, one cycle after its accept.
   always begin
      @(posedge iClk);
      #1;
      if (iRst_n && reqIf.rspValid) begin
         if (sb.size() == 0) begin
            chk("spurious_rsp", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_data", reqIf.rspData, e.data);
            chk("rsp_lat", cyc, e.cyc + 1);
         end
      end else if (sb.size() > 0 && sb[0].cyc + 1 <= cyc) begin
         chk("rsp_missing", 0, 1);
         void'(sb.pop_front());
      end
   end

   task automatic doReq(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      @(negedge iClk);
      reqIf.reqValid = 1'b1;
      reqIf.reqWe    = w;
      reqIf.reqAddr  = a;
      reqIf.reqData  = d;
      #1 chk("req_ready", reqIf.reqReady, 1);
      @(posedge iClk);
      #1;
      chk("acc_en", oRamEn, 1);
      chk("acc_we", oRamWe, (w && a != 0) ? 1 : 0);
      chk("acc_addr", oRamAddr, a);
      if (w) begin
         chk("acc_data", oRamData, d);
         if (a != 0) refMem[a] = d;
      end else begin
         e.data = (a == 0) ? '0 : refMem[a];
         e.cyc  = cyc;
         sb.push_back(e);
      end
   endtask

   task automatic idle();
      @(negedge iClk);
      reqIf.reqValid = 1'b0;
      @(posedge iClk);
      #1 chk("idle_en", oRamEn, 0);
   endtask

   task automatic checkSweep(input logic initExp);
      for (int i = 0; i < DEPTH; i++) begin
         @(posedge iClk);
         #1;
         chk("sw_en", oRamEn, 1);
         chk("sw_we", oRamWe, 1);
         chk("sw_addr", oRamAddr, i);
         chk("sw_data", oRamData, 0);
         chk("sw_rdy", reqIf.reqReady, 0);
         chk("sw_init", oInitDone, initExp);
      end
      @(posedge iClk);
      #1;
      chk("end_init", oInitDone, 1);
      chk("end_en", oRamEn, 0);
      chk("end_we", oRamWe, 0);
      chk("end_rdy", reqIf.reqReady, 1);
      for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
   endtask

   task automatic chkReset(input string tag);
      chk({tag, "_en"}, oRamEn, 0);
      chk({tag, "_we"}, oRamWe, 0);
      chk({tag, "_addr"}, oRamAddr, 0);
      chk({tag, "_data"}, oRamData, 0);
      chk({tag, "_rspv"}, reqIf.rspValid, 0);
      chk({tag, "_rspd"}, reqIf.rspData, 0);
      chk({tag, "_init"}, oInitDone, 0);
      chk({tag, "_rdy"}, reqIf.reqReady, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      iRst_n         = 1'b0;
      iClear         = 1'b0;
      reqIf.reqValid = 1'b0;
      reqIf.reqWe    = 1'b0;
      reqIf.reqAddr  = '0;
      reqIf.reqData  = '0;
      for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
      #3 chkReset("rst");
      @(negedge iClk);
      @(negedge iClk);
      iRst_n = 1'b1;

      // Initial sweep
      checkSweep(1'b0);

      // Write then read same address, back to back
      doReq(1'b1, 5'd5, 32'hDEADBEEF);
      doReq(1'b0, 5'd5, 32'h0);
      idle();
      idle();

      // Zero register: write dropped, read returns 0
      doReq(1'b1, 5'd0, 32'h12345678);
      doReq(1'b0, 5'd0, 32'h0);
      idle();
      idle();

      // Preload then back-to-back reads
      doReq(1'b1, 5'd1, 32'h11);
      doReq(1'b1, 5'd2, 32'h22);
      doReq(1'b1, 5'd3, 32'h33);
      doReq(1'b0, 5'd1, 32'h0);
      doReq(1'b0, 5'd2, 32'h0);
      doReq(1'b0, 5'd3, 32'h0);
      idle();
      idle();

      // Clear collides with a request one cycle after a read accept
      doReq(1'b0, 5'd2, 32'h0);
      @(negedge iClk);
      iClear         = 1'b1;
      reqIf.reqValid = 1'b1;
      reqIf.reqWe    = 1'b0;
      reqIf.reqAddr  = 5'd3;
      #1 chk("clr_rdy", reqIf.reqReady, 0);
      @(posedge iClk);
      #1;
      chk("clr_en", oRamEn, 0);
      chk("clr_init", oInitDone, 1);
      @(negedge iClk);
      iClear         = 1'b0;
      reqIf.reqValid = 1'b0;
      checkSweep(1'b1);
      doReq(1'b0, 5'd2, 32'h0);
      doReq(1'b0, 5'd5, 32'h0);
      idle();
      idle();

      // Asynchronous reset mid-sweep
      @(negedge iClk);
      iClear = 1'b1;
      @(negedge iClk);
      iClear = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         @(posedge iClk);
         #1;
      end
      chk("mid_addr", oRamAddr, 10);
      #2 iRst_n = 1'b0;
      #1 chkReset("arst");
      @(negedge iClk);
      iRst_n = 1'b1;
      checkSweep(1'b0);
      doReq(1'b1, 5'd7, 32'hCAFE0007);
      doReq(1'b0, 5'd7, 32'h0);
      idle();
      idle();

      chk("sb_drain", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
